// File: rtl/inst_encoder_if.sv
// Instruction-field request and instruction-memory write port bundle for inst_encoder.
// The slave modport is the encoder side; the master modport is the producer/consumer side.
interface inst_encoder_if #(
    parameter int DEPTH = 256
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          valid_i;
    logic          ready_o;
    logic [1:0]    fmt_i;
    logic [2:0]    funct3_i;
    logic [4:0]    rd_i;
    logic [4:0]    rs1_i;
    logic [4:0]    rs2_i;
    logic [31:0]   imm_i;
    logic          addr_clr_i;

    logic          wr_en_o;
    logic [31:0]   wr_addr_o;
    logic [31:0]   wr_data_o;
    logic [CW-1:0] count_o;
    logic          full_o;
    logic          err_o;

    modport slave (
        input  valid_i, fmt_i, funct3_i, rd_i, rs1_i, rs2_i, imm_i, addr_clr_i,
        output ready_o, wr_en_o, wr_addr_o, wr_data_o, count_o, full_o, err_o
    );

    modport master (
        output valid_i, fmt_i, funct3_i, rd_i, rs1_i, rs2_i, imm_i, addr_clr_i,
        input  ready_o, wr_en_o, wr_addr_o, wr_data_o, count_o, full_o, err_o
    );
endinterface

// File: rtl/inst_encoder.sv
// RV32 I/L/S/B instruction encoder that streams encoded words into instruction memory.
// Optional immediate range checking is enabled with the INST_ENCODER_IMM_CHECK_EN macro.
module inst_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 256
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    inst_encoder_if.slave bus
);
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_B = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        REJECT,
        FULL
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] count_inc;
    logic [31:0]   wr_data_q;
    logic [31:0]   wr_addr_q;
    logic [31:0]   encoded;
    logic          accept;
    logic          legal;

    function automatic logic [31:0] encode(
        input logic [1:0]  fmt,
        input logic [2:0]  funct3,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        logic [31:0] word;
        case (fmt)
            2'b00:   word = {imm[11:0], rs1, funct3, rd, OP_I};
            2'b01:   word = {imm[11:0], rs1, funct3, rd, OP_L};
            2'b10:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_S};
            default: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_B};
        endcase
        return word;
    endfunction

`ifdef INST_ENCODER_IMM_CHECK_EN
    // Branch offsets are halfword aligned, so an odd B immediate cannot be encoded.
    function automatic logic imm_legal(input logic [1:0] fmt, input logic [31:0] imm);
        logic signed [31:0] s;
        logic               ok;
        s = $signed(imm);
        if (fmt == 2'b11) begin
            ok = (s >= -32'sd4096) && (s <= 32'sd4094) && !imm[0];
        end else begin
            ok = (s >= -32'sd2048) && (s <= 32'sd2047);
        end
        return ok;
    endfunction

    assign legal     = imm_legal(bus.fmt_i, bus.imm_i);
    assign bus.err_o = (state_q == REJECT);
`else
    logic unused_imm_hi;

    assign unused_imm_hi = ^bus.imm_i[31:13];
    assign legal         = 1'b1;
    assign bus.err_o     = 1'b0;
`endif

    assign encoded   = encode(bus.fmt_i, bus.funct3_i, bus.rd_i, bus.rs1_i, bus.rs2_i, bus.imm_i);
    assign accept    = bus.valid_i && bus.ready_o;
    assign count_inc = count_q + CW'(1);

    assign bus.ready_o   = (state_q == IDLE) && !bus.addr_clr_i;
    assign bus.wr_en_o   = (state_q == WRITE);
    assign bus.wr_data_o = wr_data_q;
    assign bus.wr_addr_o = wr_addr_q;
    assign bus.count_o   = count_q;
    assign bus.full_o    = (count_q == DEPTH_C);

    // Next-state and count logic; a clear always wins over the end-of-write increment.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (bus.addr_clr_i) begin
                    count_d = '0;
                end else if (accept) begin
                    state_d = legal ? WRITE : REJECT;
                end
            end
            WRITE: begin
                if (bus.addr_clr_i) begin
                    count_d = '0;
                    state_d = IDLE;
                end else begin
                    count_d = count_inc;
                    state_d = (count_inc == DEPTH_C) ? FULL : IDLE;
                end
            end
            REJECT: begin
                state_d = IDLE;
                if (bus.addr_clr_i) begin
                    count_d = '0;
                end
            end
            FULL: begin
                if (bus.addr_clr_i) begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The write word and address are captured at acceptance so they stay stable through WRITE and after.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            count_q   <= '0;
            wr_data_q <= '0;
            wr_addr_q <= BASE_ADDR;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (accept && legal) begin
                wr_data_q <= encoded;
                wr_addr_q <= BASE_ADDR + (32'(count_q) << 2);
            end
        end
    end
endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: a reference model predicts each memory write and
// error pulse, and an independent monitor checks what the DUT actually presents.
module tb_inst_encoder;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic clk_i;
    logic rst_ni;

    inst_encoder_if #(.DEPTH(DEPTH)) bus ();

    inst_encoder #(
        .BASE_ADDR(BASE),
        .DEPTH    (DEPTH)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   err_pending = 0;
    int   model_count = 0;
    int   compared    = 0;
    int   mismatched  = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference model: immediates as plain integers, fields placed with shift-and-mask arithmetic.
    function automatic bit modelLegal(input logic [1:0] fmt, input logic [31:0] imm);
`ifdef INST_ENCODER_IMM_CHECK_EN
        int v;
        v = int'($signed(imm));
        if (fmt == 2'd3) return (v >= -4096) && (v <= 4094) && ((v % 2) == 0);
        return (v >= -2048) && (v <= 2047);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [31:0] modelEncode(input logic [1:0] fmt, input logic [2:0] f3,
                                                input logic [4:0] rd, input logic [4:0] rs1,
                                                input logic [4:0] rs2, input logic [31:0] imm);
        logic [31:0] r1, r2, d, f, w;
        r1 = 32'(rs1);
        r2 = 32'(rs2);
        d  = 32'(rd);
        f  = 32'(f3);
        case (fmt)
            2'd0: w = ((imm & 32'hFFF) << 20) | (r1 << 15) | (f << 12) | (d << 7) | 32'h13;
            2'd1: w = ((imm & 32'hFFF) << 20) | (r1 << 15) | (f << 12) | (d << 7) | 32'h03;
            2'd2: w = (((imm >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (f << 12)
                    | ((imm & 32'h1F) << 7) | 32'h23;
            default: w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                    | (r2 << 20) | (r1 << 15) | (f << 12) | (((imm >> 1) & 32'hF) << 8)
                    | (((imm >> 11) & 32'h1) << 7) | 32'h63;
        endcase
        return w;
    endfunction

    task automatic applyStimulus(input logic [1:0] fmt, input logic [2:0] f3, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                                 output bit legal);
        int   budget;
        exp_t e;
        @(posedge clk_i);
        #1;
        bus.fmt_i    = fmt;
        bus.funct3_i = f3;
        bus.rd_i     = rd;
        bus.rs1_i    = rs1;
        bus.rs2_i    = rs2;
        bus.imm_i    = imm;
        bus.valid_i  = 1'b1;
        budget       = 0;
        @(negedge clk_i);
        while (!bus.ready_o && budget < 20) begin
            @(negedge clk_i);
            budget++;
        end
        if (!bus.ready_o) begin
            mismatched++;
            compared++;
            $display("[TB] FAIL ready timeout: ready_o stayed 0 for %0d cycles", budget);
            bus.valid_i = 1'b0;
            legal       = 1'b0;
            return;
        end
        checkOutput("count before accept", 32'(bus.count_o), 32'(model_count));
        @(posedge clk_i);
        #1;
        bus.valid_i = 1'b0;
        legal       = modelLegal(fmt, imm);
        if (legal) begin
            e.addr = BASE + 32'(model_count * 4);
            e.data = modelEncode(fmt, f3, rd, rs1, rs2, imm);
            exp_q.push_back(e);
            model_count++;
        end else begin
            err_pending++;
        end
    endtask

    // Monitor: every write or error pulse the DUT shows must match a prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (bus.wr_en_o) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected write: addr 0x%08h data 0x%08h, expected no write",
                             bus.wr_addr_o, bus.wr_data_o);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("wr_data", bus.wr_data_o, e.data);
                    checkOutput("wr_addr", bus.wr_addr_o, e.addr);
                    checkOutput("ready during write", 32'(bus.ready_o), 32'h0);
                end
            end
            if (bus.err_o) begin
                compared++;
                if (err_pending == 0) begin
                    mismatched++;
                    $display("[TB] FAIL unexpected err: err_o 1, expected 0");
                end else begin
                    err_pending--;
                end
            end
        end
    end

    initial begin
        bit          legal;
        logic [1:0]  fmt;
        logic [31:0] imm;
        int          sel;

        rst_ni         = 1'b0;
        bus.valid_i    = 1'b0;
        bus.addr_clr_i = 1'b0;
        bus.fmt_i      = '0;
        bus.funct3_i   = '0;
        bus.rd_i       = '0;
        bus.rs1_i      = '0;
        bus.rs2_i      = '0;
        bus.imm_i      = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        checkOutput("reset count", 32'(bus.count_o), 32'h0);
        checkOutput("reset full", 32'(bus.full_o), 32'h0);
        checkOutput("reset wr_en", 32'(bus.wr_en_o), 32'h0);
        checkOutput("reset wr_data", bus.wr_data_o, 32'h0);
        checkOutput("reset wr_addr", bus.wr_addr_o, BASE);
        checkOutput("reset err", 32'(bus.err_o), 32'h0);
        checkOutput("reset ready", 32'(bus.ready_o), 32'h1);

        applyStimulus(2'd0, 3'd0, 5'd5, 5'd1, 5'd0, 32'hFFFF_FFFF, legal);
        applyStimulus(2'd2, 3'd2, 5'd0, 5'd3, 5'd2, 32'd8, legal);
        applyStimulus(2'd1, 3'd2, 5'd6, 5'd0, 5'd0, 32'd0, legal);
        applyStimulus(2'd3, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, legal);
        @(negedge clk_i);
        @(negedge clk_i);
        checkOutput("full count", 32'(bus.count_o), 32'(DEPTH));
        checkOutput("full flag", 32'(bus.full_o), 32'h1);

        bus.fmt_i   = 2'd0;
        bus.valid_i = 1'b1;
        repeat (4) begin
            @(negedge clk_i);
            checkOutput("ready while full", 32'(bus.ready_o), 32'h0);
        end
        checkOutput("count held while full", 32'(bus.count_o), 32'(DEPTH));
        @(posedge clk_i);
        #1;
        bus.valid_i    = 1'b0;
        bus.addr_clr_i = 1'b1;
        @(posedge clk_i);
        #1 bus.addr_clr_i = 1'b0;
        model_count = 0;
        @(negedge clk_i);
        checkOutput("count after clear", 32'(bus.count_o), 32'h0);
        checkOutput("full after clear", 32'(bus.full_o), 32'h0);
        checkOutput("ready after clear", 32'(bus.ready_o), 32'h1);

        applyStimulus(2'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd2048, legal);
        repeat (2) @(negedge clk_i);
        checkOutput("count after imm 2048", 32'(bus.count_o), 32'(model_count));

        applyStimulus(2'd1, 3'd4, 5'd9, 5'd7, 5'd0, 32'd100, legal);
        rst_ni = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("wr_en after reset in write", 32'(bus.wr_en_o), 32'h0);
        checkOutput("count after reset in write", 32'(bus.count_o), 32'h0);
        #1 rst_ni = 1'b1;
        model_count = 0;
        @(negedge clk_i);
        checkOutput("ready after reset release", 32'(bus.ready_o), 32'h1);

        for (int i = 0; i < 60; i++) begin
            if (model_count == DEPTH) begin
                @(posedge clk_i);
                #1 bus.addr_clr_i = 1'b1;
                @(posedge clk_i);
                #1 bus.addr_clr_i = 1'b0;
                model_count = 0;
            end
            fmt = 2'($urandom_range(0, 3));
            sel = int'($urandom_range(0, 9));
            if (sel < 6) begin
                imm = (fmt == 2'd3) ? 32'(int'($urandom_range(0, 4095)) * 2 - 4096)
                                    : 32'(int'($urandom_range(0, 4095)) - 2048);
            end else if (sel < 8) begin
                imm = 32'(int'($urandom_range(0, 8191)) - 4096);
            end else begin
                imm = $urandom;
            end
            applyStimulus(fmt, 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm, legal);
            if (legal && $urandom_range(0, 5) == 0) begin
                bus.addr_clr_i = 1'b1;
                @(posedge clk_i);
                #1 bus.addr_clr_i = 1'b0;
                model_count = 0;
            end
        end

        repeat (4) @(negedge clk_i);
        checkOutput("final count", 32'(bus.count_o), 32'(model_count));
        checkOutput("writes outstanding", 32'(exp_q.size()), 32'h0);
        checkOutput("errors outstanding", 32'(err_pending), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
